// File: rtl/int_issue_ctrl_if.sv
// Handshake and bus bundle between decode, the integer issue controller,
// the execute stage and the shared serial shifter.
interface int_issue_ctrl_if;
  // Control and decode-side handshake
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rs2_shamt;

  // Micro-op handshake toward execute
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_use_imm;
  logic        out_src_sh;
  logic        out_illegal;

  // Serial shifter sequencing
  logic        sh_load;
  logic        sh_dir;
  logic        sh_arith;
  logic        sh_step;

  // Side that offers instructions and consumes micro-ops
  modport master (
    output flush, in_valid, in_instr, rs2_shamt, out_ready,
    input  in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
           out_imm, out_use_imm, out_src_sh, out_illegal,
           sh_load, sh_dir, sh_arith, sh_step
  );

  // The issue controller itself
  modport slave (
    input  flush, in_valid, in_instr, rs2_shamt, out_ready,
    output in_ready, out_valid, out_alu_op, out_rs1, out_rs2, out_rd,
           out_imm, out_use_imm, out_src_sh, out_illegal,
           sh_load, sh_dir, sh_arith, sh_step
  );
endinterface

// File: rtl/int_issue_ctrl.sv
// Integer issue controller: classifies RV32I OP / OP_IMM instructions,
// issues single-cycle ALU micro-ops directly and sequences shifts through
// a 1-bit-per-step serial shifter before issuing their micro-op.
module int_issue_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  int_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRX     = 3'b101;

  // ------------------------------------------------------------------
  // Instruction field extraction
  // ------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_op;
  logic        is_op_imm;
  logic        funct3_shift;
  logic [31:0] imm_sext;

  assign opcode       = bus.in_instr[6:0];
  assign funct3       = bus.in_instr[14:12];
  assign funct7       = bus.in_instr[31:25];
  assign is_op        = (opcode == OPC_OP);
  assign is_op_imm    = (opcode == OPC_OP_IMM);
  assign funct3_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);

  // I-type immediate, sign bit replicated across the upper bits
  assign imm_sext[11:0] = bus.in_instr[31:20];
  for (genvar gi = 12; gi < 32; gi++) begin : g_imm_sext
    assign imm_sext[gi] = bus.in_instr[31];
  end

  // ------------------------------------------------------------------
  // Decode of the offered instruction
  // ------------------------------------------------------------------
  logic        dec_illegal;
  logic        dec_shift;
  logic        dec_alt;
  logic [3:0]  dec_alu_op;
  logic [31:0] dec_imm;
  logic [4:0]  dec_shamt;
  logic        dec_dir;
  logic        dec_arith;

  // Flag every encoding this stage does not execute
  always_comb begin
    dec_illegal = 1'b0;
    if (!is_op && !is_op_imm) begin
      dec_illegal = 1'b1;
    end else if (is_op) begin
      if ((funct7 != F7_BASE) && (funct7 != F7_ALT)) begin
        dec_illegal = 1'b1;
      end else if ((funct7 == F7_ALT) && (funct3 != F3_ADD) && (funct3 != F3_SRX)) begin
        dec_illegal = 1'b1;
      end
    end else begin
      // For OP_IMM only the shift forms constrain imm[11:5]
      if ((funct3 == F3_SLL) && (funct7 != F7_BASE)) begin
        dec_illegal = 1'b1;
      end else if ((funct3 == F3_SRX) && (funct7 != F7_BASE) && (funct7 != F7_ALT)) begin
        dec_illegal = 1'b1;
      end
    end
  end

  // alt is instr[30] for R-type and for immediate right shifts only;
  // ADDI/XORI/... ignore bit 30 since it belongs to the immediate.
  assign dec_shift  = !dec_illegal && funct3_shift;
  assign dec_alt    = !dec_illegal &&
                      (is_op ? funct7[5] : ((funct3 == F3_SRX) && funct7[5]));
  assign dec_alu_op = dec_illegal ? 4'd0 : {dec_alt, funct3};
  assign dec_imm    = is_op_imm ? imm_sext : 32'd0;
  assign dec_shamt  = is_op_imm ? bus.in_instr[24:20] : bus.rs2_shamt;
  assign dec_dir    = funct3[2];
  assign dec_arith  = funct3[2] & funct7[5];

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  state_t      state_reg;
  state_t      state_next;
  logic        out_valid_reg;
  logic        out_valid_next;
  logic [4:0]  count_reg;
  logic [4:0]  count_next;
  logic        sh_dir_reg;
  logic        sh_dir_next;
  logic        sh_arith_reg;
  logic        sh_arith_next;
  logic        fields_load;
  logic        in_ready_int;

  // State register and the registers the FSM steers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      count_reg     <= 5'd0;
      sh_dir_reg    <= 1'b0;
      sh_arith_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      count_reg     <= count_next;
      sh_dir_reg    <= sh_dir_next;
      sh_arith_reg  <= sh_arith_next;
    end
  end

  // Next-state, handshake and shift-counter sequencing
  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    count_next     = count_reg;
    sh_dir_next    = sh_dir_reg;
    sh_arith_next  = sh_arith_reg;
    fields_load    = 1'b0;
    in_ready_int   = 1'b0;

    if (bus.flush) begin
      // Abort whatever is in flight; nothing is accepted this cycle
      state_next     = IDLE;
      out_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Single output register may drain and refill in one cycle
          in_ready_int = ~out_valid_reg | bus.out_ready;
          if (bus.in_valid && in_ready_int) begin
            fields_load = 1'b1;
            if (dec_shift) begin
              // Any pending micro-op drains now; the shift result
              // becomes valid only when sequencing completes.
              out_valid_next = 1'b0;
              count_next     = dec_shamt;
              sh_dir_next    = dec_dir;
              sh_arith_next  = dec_arith;
              state_next     = LOAD;
            end else begin
              out_valid_next = 1'b1;
            end
          end else if (bus.out_ready) begin
            out_valid_next = 1'b0;
          end
        end

        LOAD: begin
          if (count_reg == 5'd0) begin
            state_next     = DONE;
            out_valid_next = 1'b1;
          end else begin
            state_next = STEP;
          end
        end

        STEP: begin
          count_next = count_reg - 5'd1;
          if (count_reg == 5'd1) begin
            state_next     = DONE;
            out_valid_next = 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
          end
        end

        default: begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Micro-op field registers
  // ------------------------------------------------------------------
  logic [3:0]  alu_op_reg;
  logic [4:0]  rs1_reg;
  logic [4:0]  rs2_reg;
  logic [4:0]  rd_reg;
  logic [31:0] imm_reg;
  logic        use_imm_reg;
  logic        src_sh_reg;
  logic        illegal_reg;

  // Capture decoded fields on acceptance; they hold until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_reg  <= 4'd0;
      rs1_reg     <= 5'd0;
      rs2_reg     <= 5'd0;
      rd_reg      <= 5'd0;
      imm_reg     <= 32'd0;
      use_imm_reg <= 1'b0;
      src_sh_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (fields_load) begin
      alu_op_reg  <= dec_alu_op;
      rs1_reg     <= bus.in_instr[19:15];
      rs2_reg     <= bus.in_instr[24:20];
      rd_reg      <= bus.in_instr[11:7];
      imm_reg     <= dec_imm;
      use_imm_reg <= is_op_imm;
      src_sh_reg  <= dec_shift;
      illegal_reg <= dec_illegal;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_alu_op  = alu_op_reg;
  assign bus.out_rs1     = rs1_reg;
  assign bus.out_rs2     = rs2_reg;
  assign bus.out_rd      = rd_reg;
  assign bus.out_imm     = imm_reg;
  assign bus.out_use_imm = use_imm_reg;
  assign bus.out_src_sh  = src_sh_reg;
  assign bus.out_illegal = illegal_reg;

  // Shifter strobes decode straight from the state register, so a flush
  // or reset removes them as soon as the state leaves LOAD/STEP.
  assign bus.sh_load     = (state_reg == LOAD);
  assign bus.sh_step     = (state_reg == STEP);
  assign bus.sh_dir      = sh_dir_reg;
  assign bus.sh_arith    = sh_arith_reg;

endmodule
